// File: rtl/br_fifo_flops_push_credit_multi.sv
// Multi-channel flop-based FIFO with a credit-based push interface and
// independent per-channel valid/ready pop interfaces. Each channel has its own
// storage, pointers, credit counter and credit-return line.
// Optional feature macro: BR_FIFO_MULTI_OVERFLOW_STATUS_EN adds a sticky
// per-channel push_overflow status output.
module br_fifo_flops_push_credit_multi #(
  parameter int NumChannels        = 2,
  parameter int Depth              = 8,
  parameter int Width              = 8,
  parameter int MaxCredit          = Depth,
  parameter int RegisterPopOutputs = 0,
  localparam int ChW    = (NumChannels > 1) ? $clog2(NumChannels) : 1,
  localparam int CountW = $clog2(MaxCredit + 1),
  localparam int ItemW  = $clog2(Depth + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_sender_in_reset,
  output logic                          push_receiver_in_reset,
  input  logic                          push_credit_stall,
  output logic [NumChannels-1:0]        push_credit,
  input  logic                          push_valid,
  input  logic [ChW-1:0]                push_channel,
  input  logic [Width-1:0]              push_data,
  input  logic [CountW-1:0]             credit_initial_push,
  input  logic [NumChannels*CountW-1:0] credit_withhold_push,
  output logic [NumChannels*CountW-1:0] credit_count_push,
  output logic [NumChannels-1:0]        push_full,
  input  logic [NumChannels-1:0]        pop_ready,
  output logic [NumChannels-1:0]        pop_valid,
  output logic [NumChannels*Width-1:0]  pop_data,
  output logic [NumChannels-1:0]        pop_empty,
  output logic [NumChannels*ItemW-1:0]  pop_items
`ifdef BR_FIFO_MULTI_OVERFLOW_STATUS_EN
  ,
  output logic [NumChannels-1:0]        push_overflow
`endif
);

  localparam int PtrW   = $clog2(Depth);
  localparam int NumIds = 2 ** ChW;

  logic                   receiver_in_reset;
  logic                   push_act;
  logic                   bad_chan;
  logic [NumIds-1:0]      chan_legal;
  logic [NumChannels-1:0] push_ok;
  logic [NumChannels-1:0] push_err;
  logic [NumChannels-1:0] pop_fire;
  logic [NumChannels-1:0] valid;
  logic [NumChannels-1:0] full;
  logic [NumChannels-1:0] credit;

  // Delayed copy of rst tells the sender we are still coming out of reset
  always_ff @(posedge clk) begin
    receiver_in_reset <= rst;
  end

  assign push_receiver_in_reset = receiver_in_reset;

  // Mark which encodable channel ids correspond to a real channel
  always_comb begin
    chan_legal = '0;
    for (int i = 0; i < NumIds; i++) chan_legal[i] = (i < NumChannels);
  end

  // Pushes are ignored while either side of the link is in reset
  assign push_act    = push_valid && !rst && !push_sender_in_reset;
  assign bad_chan    = push_act && !chan_legal[push_channel];
  assign push_credit = credit;
  assign pop_valid   = valid;
  assign push_full   = full;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [CountW-1:0] cnt;
    logic [CountW-1:0] withhold;
    logic [ItemW-1:0]  ram_cnt;
    logic [ItemW-1:0]  items;
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [Width-1:0]  mem [Depth];
    logic              push_hit;
    logic              ram_pop;

    assign withhold    = credit_withhold_push[c*CountW +: CountW];
    assign push_hit    = push_act && (push_channel == ChW'(c));
    assign full[c]     = (items == ItemW'(Depth));
    assign pop_fire[c] = valid[c] && pop_ready[c];
    // A pop on the same edge frees the slot, so a push to a full channel is fine then
    assign push_ok[c]  = push_hit && (!full[c] || pop_fire[c]);
    assign push_err[c] = push_hit && full[c] && !pop_fire[c];
    assign credit[c]   = !rst && !receiver_in_reset && !push_sender_in_reset &&
                         !push_credit_stall && (cnt > withhold);

    assign pop_empty[c]                         = (items == '0);
    assign pop_items[c*ItemW +: ItemW]          = items;
    assign credit_count_push[c*CountW +: CountW] = cnt;

    // Credit counter: +1 per pop, -1 per returned credit, saturating at MaxCredit
    always_ff @(posedge clk) begin
      if (rst || push_sender_in_reset) begin
        cnt <= credit_initial_push;
      end else if (pop_fire[c] && !credit[c]) begin
        if (cnt != CountW'(MaxCredit)) cnt <= cnt + CountW'(1);
      end else if (credit[c] && !pop_fire[c]) begin
        cnt <= cnt - CountW'(1);
      end
    end

    // Flop RAM write port
    always_ff @(posedge clk) begin
      if (push_ok[c]) mem[wr_ptr] <= push_data;
    end

    // Write/read pointers and RAM occupancy
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        ram_cnt <= '0;
      end else begin
        if (push_ok[c]) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
        if (ram_pop)    rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
        ram_cnt <= ram_cnt + ItemW'(push_ok[c]) - ItemW'(ram_pop);
      end
    end

    if (RegisterPopOutputs == 0) begin : g_direct
      assign ram_pop                     = pop_fire[c];
      assign items                       = ram_cnt;
      assign valid[c]                    = (ram_cnt != '0);
      assign pop_data[c*Width +: Width]  = mem[rd_ptr];
    end else begin : g_reg
      logic             vld_p1;
      logic [Width-1:0] data_p1;

      // Refill the output slot whenever it is empty or being popped
      assign ram_pop                    = (ram_cnt != '0) && (!vld_p1 || pop_fire[c]);
      assign items                      = ram_cnt + ItemW'(vld_p1);
      assign valid[c]                   = vld_p1;
      assign pop_data[c*Width +: Width] = data_p1;

      // ---- stage p1: output register counts as one storage slot ----
      always_ff @(posedge clk) begin
        if (rst)              vld_p1 <= 1'b0;
        else if (ram_pop)     vld_p1 <= 1'b1;
        else if (pop_fire[c]) vld_p1 <= 1'b0;
      end

      // Output data register, loaded alongside vld_p1
      always_ff @(posedge clk) begin
        if (ram_pop) data_p1 <= mem[rd_ptr];
      end
    end
  end

`ifdef BR_FIFO_MULTI_OVERFLOW_STATUS_EN
  // Sticky overflow status; an invalid channel id is reported on channel 0
  always_ff @(posedge clk) begin
    if (rst) push_overflow <= '0;
    else     push_overflow <= push_overflow | push_err | NumChannels'(bad_chan);
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst) !((|push_err) || bad_chan))
    else $warning("push to a full or nonexistent channel");
`else
  overflow_a: assert property (@(posedge clk) disable iff (rst) !((|push_err) || bad_chan))
    else $fatal(1, "push to a full or nonexistent channel");
`endif

endmodule

// File: tb/tb_br_fifo_flops_push_credit_multi.sv
// Bench for br_fifo_flops_push_credit_multi (NumChannels=2, Depth=8, Width=8).
// A negedge monitor checks popped data against per-channel scoreboard queues
// and tallies credit pulses; a table drives the credit withhold/stall phases.
module tb_br_fifo_flops_push_credit_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sir = 1'b0;
  logic        stall = 1'b0;
  logic        pv = 1'b0;
  logic        pch = 1'b0;
  logic [7:0]  pd = '0;
  logic [3:0]  cinit = 4'd8;
  logic [7:0]  withhold = '0;
  logic [1:0]  pready = '0;

  logic        rir;
  logic [1:0]  pcredit;
  logic [7:0]  ccount;
  logic [1:0]  pfull;
  logic [1:0]  pvalid;
  logic [15:0] pdata;
  logic [1:0]  pempty;
  logic [7:0]  pitems;
`ifdef BR_FIFO_MULTI_OVERFLOW_STATUS_EN
  logic [1:0]  povf;
`endif

  int tests = 0;
  int fails = 0;
  int cred_tot[2] = '{0, 0};
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  typedef struct {
    int wh0, wh1, stall, reload, cycles, cred0, cred1, cnt0, cnt1;
  } crow_t;
  crow_t tbl[6];

  br_fifo_flops_push_credit_multi dut (
    .clk                    (clk),
    .rst                    (rst),
    .push_sender_in_reset   (sir),
    .push_receiver_in_reset (rir),
    .push_credit_stall      (stall),
    .push_credit            (pcredit),
    .push_valid             (pv),
    .push_channel           (pch),
    .push_data              (pd),
    .credit_initial_push    (cinit),
    .credit_withhold_push   (withhold),
    .credit_count_push      (ccount),
    .push_full              (pfull),
    .pop_ready              (pready),
    .pop_valid              (pvalid),
    .pop_data               (pdata),
    .pop_empty              (pempty),
    .pop_items              (pitems)
`ifdef BR_FIFO_MULTI_OVERFLOW_STATUS_EN
    ,
    .push_overflow          (povf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int items(input int c);
    return int'(pitems[c*4 +: 4]);
  endfunction

  function automatic int cnt(input int c);
    return int'(ccount[c*4 +: 4]);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_beats(input int ch, input int base, input int n, input bit enq);
    for (int i = 0; i < n; i++) begin
      pv  = 1'b1;
      pch = ch[0];
      pd  = 8'(base + i);
      if (enq) begin
        if (ch == 0) q0.push_back(8'(base + i));
        else         q1.push_back(8'(base + i));
      end
      tick(1);
    end
    pv = 1'b0;
  endtask

  // Scoreboard pop side and credit tally, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (pcredit[0]) cred_tot[0]++;
      if (pcredit[1]) cred_tot[1]++;
      if (pvalid[0] && pready[0]) begin
        if (q0.size() == 0) check("pop_unexpected_ch0", 1, 0);
        else                check("pop_data_ch0", int'(pdata[7:0]), int'(q0.pop_front()));
      end
      if (pvalid[1] && pready[1]) begin
        if (q1.size() == 0) check("pop_unexpected_ch1", 1, 0);
        else                check("pop_data_ch1", int'(pdata[15:8]), int'(q1.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s0, s1;
    tbl[0] = '{3, 0, 0, 1, 12, 5, 8, 3, 0};
    tbl[1] = '{0, 0, 0, 0, 8,  3, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 12, 0, 0, 8, 8};
    tbl[3] = '{0, 0, 0, 0, 12, 8, 8, 0, 0};
    tbl[4] = '{8, 2, 0, 1, 12, 0, 6, 8, 2};
    tbl[5] = '{0, 0, 0, 0, 12, 8, 2, 0, 0};

    // Reset state
    tick(3);
    check("rst_rir", int'(rir), 1);
    check("rst_credit", int'(pcredit), 0);
    check("rst_pop_valid", int'(pvalid), 0);
    check("rst_pop_empty", int'(pempty), 3);
    check("rst_push_full", int'(pfull), 0);
    check("rst_pop_items", int'(pitems), 0);
    check("rst_credit_count", int'(ccount), 8'h88);

    // Reset release and initial credit burst
    rst = 1'b0;
    s0 = cred_tot[0];
    s1 = cred_tot[1];
    #1;
    check("rir_hold", int'(rir), 1);
    check("credit_during_rir", int'(pcredit), 0);
    tick(1);
    check("rir_fall", int'(rir), 0);
    check("credit_first", int'(pcredit), 3);
    tick(11);
    check("init_credits_ch0", cred_tot[0] - s0, 8);
    check("init_credits_ch1", cred_tot[1] - s1, 8);
    check("init_count_ch0", cnt(0), 0);
    check("init_count_ch1", cnt(1), 0);

    // Five beats into ch1 held back, then drained in order
    push_beats(1, 8'h10, 5, 1'b1);
    check("ch1_items5", items(1), 5);
    check("ch0_valid_idle", int'(pvalid[0]), 0);
    check("ch1_valid", int'(pvalid[1]), 1);
    check("ch1_head", int'(pdata[15:8]), 8'h10);
    s0 = cred_tot[0];
    s1 = cred_tot[1];
    pready[1] = 1'b1;
    tick(5);
    pready[1] = 1'b0;
    tick(6);
    check("ch1_items0", items(1), 0);
    check("ch1_credits5", cred_tot[1] - s1, 5);
    check("ch0_credits0", cred_tot[0] - s0, 0);

    // Fill ch0, push and pop together while full, then drain
    push_beats(0, 8'h20, 8, 1'b1);
    check("ch0_full", int'(pfull[0]), 1);
    check("ch0_items8", items(0), 8);
    check("ch1_not_full", int'(pfull[1]), 0);
    pready[0] = 1'b1;
    push_beats(0, 8'h28, 1, 1'b1);
    pready[0] = 1'b0;
    check("ch0_items_kept", items(0), 8);
    check("ch0_full_kept", int'(pfull[0]), 1);
    check("ch1_untouched", items(1), 0);
    pready[0] = 1'b1;
    tick(8);
    pready[0] = 1'b0;
    check("ch0_empty", int'(pempty[0]), 1);
    check("ch0_drained", items(0), 0);

    // Credit withhold / stall phases
    for (int i = 0; i < 6; i++) begin
      withhold = {4'(tbl[i].wh1), 4'(tbl[i].wh0)};
      stall    = (tbl[i].stall != 0);
      s0 = cred_tot[0];
      s1 = cred_tot[1];
      if (tbl[i].reload != 0) begin
        sir = 1'b1;
        tick(1);
        sir = 1'b0;
      end
      tick(tbl[i].cycles);
      check($sformatf("tbl%0d_cred0", i), cred_tot[0] - s0, tbl[i].cred0);
      check($sformatf("tbl%0d_cred1", i), cred_tot[1] - s1, tbl[i].cred1);
      check($sformatf("tbl%0d_cnt0", i), cnt(0), tbl[i].cnt0);
      check($sformatf("tbl%0d_cnt1", i), cnt(1), tbl[i].cnt1);
    end
    stall = 1'b0;
    withhold = '0;

    // Sender reset mid-traffic: data kept, pushes ignored, credits silenced
    push_beats(1, 8'h30, 3, 1'b1);
    sir = 1'b1;
    pv  = 1'b1;
    pch = 1'b1;
    pd  = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("sir_credit%0d", i), int'(pcredit), 0);
      tick(1);
    end
    sir = 1'b0;
    pv  = 1'b0;
    check("sir_reload", int'(ccount), 8'h88);
    check("sir_items_kept", items(1), 3);
    pready[1] = 1'b1;
    tick(3);
    pready[1] = 1'b0;
    check("sir_drained", items(1), 0);
    tick(12);

`ifdef BR_FIFO_MULTI_OVERFLOW_STATUS_EN
    // Overflow status: ninth beat into a full channel
    push_beats(0, 8'h40, 8, 1'b1);
    check("ovf_clear_before", int'(povf), 0);
    push_beats(0, 8'h48, 1, 1'b0);
    check("ovf_set", int'(povf[0]), 1);
    check("ovf_items", items(0), 8);
    tick(3);
    check("ovf_sticky", int'(povf[0]), 1);
    check("ovf_other", int'(povf[1]), 0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    q0.delete();
    check("ovf_rst_clear", int'(povf), 0);
    check("ovf_rst_items", items(0), 0);
    tick(2);
`endif

    check("sb_empty_ch0", q0.size(), 0);
    check("sb_empty_ch1", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/br_fifo_flops_push_credit_multi.md
Name: br_fifo_flops_push_credit_multi

Overview:
Single-clock, multi-channel flop-based FIFO with a credit-based push interface and independent per-channel valid/ready pop interfaces. It generalises the single-channel push-credit FIFO to NumChannels virtual channels. Each channel has its own storage partition, credit counter, occupancy status and credit-return line, so one stalled channel never blocks another. It sits at the receiving end of a credit link, downstream of a br_credit_sender plus optional pipeline delay.

Parameters:
NumChannels, 2, number of virtual channels (>=1)
Depth, 8, entries per channel (>=2; need not be a power of 2)
Width, 8, data bits per entry (>=1)
MaxCredit, Depth, credit counter saturation limit (>=Depth)
RegisterPopOutputs, 0, 1 = add one register stage on pop_valid/pop_data per channel

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
push_sender_in_reset  in  1  sender reports it is in reset
push_receiver_in_reset  out  1  this block is in reset
push_credit_stall  in  1  suppresses all credit returns
push_credit  out  NumChannels  per-channel one-credit return pulse
push_valid  in  1  push beat valid
push_channel  in  $clog2(NumChannels) (min 1)  target channel of push beat
push_data  in  Width  push payload
credit_initial_push  in  CountW=$clog2(MaxCredit+1)  reset credit value, all channels
credit_withhold_push  in  NumChannels*CountW  per-channel credits held back
credit_count_push  out  NumChannels*CountW  per-channel credit counters
push_full  out  NumChannels  channel storage full
pop_ready  in  NumChannels  per-channel pop ready
pop_valid  out  NumChannels  per-channel pop valid
pop_data  out  NumChannels*Width  per-channel pop data
pop_empty  out  NumChannels  channel storage empty
pop_items  out  NumChannels*$clog2(Depth+1)  per-channel occupancy

Behaviour:
- Reset state (rst high): credit_count = credit_initial_push; items = 0; wr/rd pointers = 0.
- Reset output values: push_credit=0, pop_valid=0, pop_empty=all 1, push_full=0, pop_items=0.
- push_receiver_in_reset: registered copy of rst; high during rst and for 1 cycle after deassertion.
- While push_sender_in_reset=1, the block behaves as follows:
  - credit counters reload credit_initial_push;
  - push_valid is ignored;
  - push_credit is 0;
  - stored data is kept.
- Credit return for channel c:
  - push_credit[c] = !rst && !push_receiver_in_reset && !push_sender_in_reset && !push_credit_stall && credit_count[c] > credit_withhold[c].
  - push_credit[c] is combinational from registered state.
  - At most 1 credit per channel per cycle.
- Credit counter per channel, updated each cycle: +1 on a pop of that channel, -1 on push_credit[c]. Both in the same cycle gives net 0. The counter saturates at MaxCredit.
- Push: a beat with push_valid=1 writes entry wr_ptr[push_channel]. The pointer advances and wraps from Depth-1 to 0.
  - A push to a full channel is a sender protocol error: flagged by assertion, data dropped, state unchanged.
  - A push_channel value >= NumChannels is also an error: flagged by assertion, beat dropped.
- Pop: a pop happens when pop_valid[c] && pop_ready[c]. pop_valid[c] may not depend on pop_ready[c]. Once pop_valid is high it stays high with stable pop_data until popped.
- Cut-through latency, push to pop_valid:
  - RegisterPopOutputs=0: 1 cycle, read from flop RAM.
  - RegisterPopOutputs=1: 2 cycles. The output register counts as a storage slot, so usable capacity stays Depth.
- Pop to credit latency: the credit counter increments on the pop edge, so push_credit can assert the following cycle.
- Simultaneous push and pop on the same full channel: the push is legal only if the sender held a credit; the pop frees a slot the same cycle; items is unchanged.
- push_full[c] = (items[c]==Depth); pop_empty[c] = (items[c]==0); both registered-state derived.
- Channels are fully independent; there is no arbitration.

Optional Feature:
Macro BR_FIFO_MULTI_OVERFLOW_STATUS_EN.
- Defined: adds output push_overflow [NumChannels], a sticky per-channel flag. It is set the cycle after a push to a full channel or an invalid channel (channel 0 is flagged for an invalid id). It is cleared only by rst. The overflow assertion becomes non-fatal.
- Not defined: no port; overflow is caught by a fatal assertion only.

Test Plan:
1. NumChannels=2, Depth=8, credit_initial=8, withhold=0, release rst -> push_receiver_in_reset falls 1 cycle after rst; push_credit[0] and push_credit[1] each pulse 8 consecutive cycles; credit_count reaches 0.
2. Push 5 beats to ch1 (data 0x10..0x14), pop_ready[1]=0 -> pop_items[1]=5, pop_valid[0]=0; then pop_ready[1]=1 -> data 0x10..0x14 in order, 5 credits returned on push_credit[1] only.
3. Fill ch0 with 8 beats -> push_full[0]=1. Same cycle as one pop, push one beat -> items stays 8; ch1 unaffected. Draining 8 beats -> pop_empty[0]=1.
4. credit_withhold[ch0]=3, credit_initial=8 -> exactly 5 credits on ch0. Then withhold=0 -> 3 more credits. With push_credit_stall=1 -> no credits on any channel.
5. Assert push_sender_in_reset mid-traffic for 4 cycles -> push_credit=0, credit_count reloads 8, stored items retained, pushes ignored.
6. With BR_FIFO_MULTI_OVERFLOW_STATUS_EN, push 9 beats to Depth=8 ch0 without popping -> push_overflow[0]=1 from the cycle after beat 9 until rst; items[0]=8.
